// File: rtl/buffer_metrics_unit_if.sv
// buffer_metrics_unit_if: buffer snapshot inputs and metric outputs of the buffer metrics unit
interface buffer_metrics_unit_if;
  logic [17:0] buffer1_o;
  logic [17:0] buffer2_o;
  logic [17:0] buffer3_o;
  logic [17:0] buffer4_o;
  logic [2:0] L1;
  logic [2:0] L2;
  logic [2:0] L3;
  logic [2:0] L4;
  logic [5:0] RS;
  logic [5:0] LS;
  logic rel_mode;
  logic clk_out;
  logic tick;
  modport master (
    output buffer1_o, buffer2_o, buffer3_o, buffer4_o,
    input L1, L2, L3, L4, RS, LS, rel_mode, clk_out, tick
  );
  modport slave (
    input buffer1_o, buffer2_o, buffer3_o, buffer4_o,
    output L1, L2, L3, L4, RS, LS, rel_mode, clk_out, tick
  );
endinterface

// File: rtl/buffer_metrics_unit.sv
// buffer_metrics_unit: per-buffer valid counts, reliability/latency scores, mode and slow scheduling tick
module buffer_metrics_unit #(
  parameter int DIV_HALF = 75000000
) (
  input logic clk,
  input logic rst,
  buffer_metrics_unit_if.slave bus
);
  localparam int CW = DIV_HALF > 1 ? $clog2(DIV_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_HALF - 1);
  function automatic logic [2:0] pop6(input logic [17:0] b);
    logic [2:0] n;
    n = '0;
    for (int k = 0; k < 6; k++) n = n + 3'(b[3*k]);
    return n;
  endfunction
  logic [2:0] w_l1, w_l2, w_l3, w_l4;
  logic [5:0] w_rs, w_ls;
  logic w_wrap;
  logic [2:0] r_l1, r_l2, r_l3, r_l4;
  logic [5:0] r_rs, r_ls;
  logic r_rel_mode, r_clk_out, r_tick;
  logic [CW-1:0] r_cnt;
  always_comb begin
    w_l1 = pop6(bus.buffer1_o);
    w_l2 = pop6(bus.buffer2_o);
    w_l3 = pop6(bus.buffer3_o);
    w_l4 = pop6(bus.buffer4_o);
    w_rs = 6'(w_l1 + 2 * w_l2 + 3 * w_l3 + 4 * w_l4);
    w_ls = 6'(4 * w_l1 + 3 * w_l2 + 2 * w_l3 + w_l4);
    w_wrap = r_cnt == LAST;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_l1 <= '0;
      r_l2 <= '0;
      r_l3 <= '0;
      r_l4 <= '0;
      r_rs <= '0;
      r_ls <= '0;
      r_rel_mode <= 1'b0;
      r_clk_out <= 1'b0;
      r_tick <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_l1 <= w_l1;
      r_l2 <= w_l2;
      r_l3 <= w_l3;
      r_l4 <= w_l4;
      r_rs <= w_rs;
      r_ls <= w_ls;
      r_rel_mode <= w_rs >= w_ls;
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      r_clk_out <= r_clk_out ^ w_wrap;
      r_tick <= w_wrap & ~r_clk_out;
    end
  end
  assign bus.L1 = r_l1;
  assign bus.L2 = r_l2;
  assign bus.L3 = r_l3;
  assign bus.L4 = r_l4;
  assign bus.RS = r_rs;
  assign bus.LS = r_ls;
  assign bus.rel_mode = r_rel_mode;
  assign bus.clk_out = r_clk_out;
  assign bus.tick = r_tick;
endmodule

// File: tb/tb_buffer_metrics_unit.sv
// tb_buffer_metrics_unit: randomized and directed scoreboard bench for buffer_metrics_unit
module tb_buffer_metrics_unit;
  localparam int DH = 4;
  localparam logic [17:0] VMASK = 18'h09249;
  typedef struct {
    int l1, l2, l3, l4, rs, ls, rm, co, tk;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int k = 0;
  exp_t q[$];
  buffer_metrics_unit_if bus();
  buffer_metrics_unit #(.DIV_HALF(DH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask
  task automatic drive(input logic [17:0] a, input logic [17:0] b, input logic [17:0] c, input logic [17:0] d, input logic r);
    exp_t e;
    @(negedge clk);
    bus.buffer1_o = a;
    bus.buffer2_o = b;
    bus.buffer3_o = c;
    bus.buffer4_o = d;
    rst = r;
    k = r ? 0 : k + 1;
    e.l1 = r ? 0 : $countones(a & VMASK);
    e.l2 = r ? 0 : $countones(b & VMASK);
    e.l3 = r ? 0 : $countones(c & VMASK);
    e.l4 = r ? 0 : $countones(d & VMASK);
    e.rs = e.l1 + 2 * e.l2 + 3 * e.l3 + 4 * e.l4;
    e.ls = 4 * e.l1 + 3 * e.l2 + 2 * e.l3 + e.l4;
    e.rm = r ? 0 : int'(e.rs >= e.ls);
    e.co = r ? 0 : int'((k / DH) % 2 == 1);
    e.tk = r ? 0 : int'(k % (2 * DH) == DH);
    q.push_back(e);
  endtask
  function automatic logic [17:0] rnd();
    return 18'($urandom);
  endfunction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("L1", int'(bus.L1), e.l1);
        chk("L2", int'(bus.L2), e.l2);
        chk("L3", int'(bus.L3), e.l3);
        chk("L4", int'(bus.L4), e.l4);
        chk("RS", int'(bus.RS), e.rs);
        chk("LS", int'(bus.LS), e.ls);
        chk("rel_mode", int'(bus.rel_mode), e.rm);
        chk("clk_out", int'(bus.clk_out), e.co);
        chk("tick", int'(bus.tick), e.tk);
      end
    end
  end
  initial begin
    bus.buffer1_o = '0;
    bus.buffer2_o = '0;
    bus.buffer3_o = '0;
    bus.buffer4_o = '0;
    repeat (2) drive(rnd(), rnd(), rnd(), rnd(), 1'b1);
    drive(18'h09249, 18'h0, 18'h00001, 18'h00009, 1'b0);
    drive(18'h0, 18'h36DB6, 18'h0, 18'h0, 1'b0);
    drive(18'h0, 18'h0, 18'h0, 18'h09249, 1'b0);
    drive(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 1'b0);
    drive(18'h0, 18'h0, 18'h0, 18'h0, 1'b0);
    drive(18'h0, 18'h0, 18'h09249, 18'h0, 1'b0);
    drive(18'h0, 18'h0, 18'h0, 18'h0, 1'b0);
    repeat (10) drive(rnd(), rnd(), rnd(), rnd(), 1'b0);
    drive(rnd(), rnd(), rnd(), rnd(), 1'b1);
    repeat (5) drive(rnd(), rnd(), rnd(), rnd(), 1'b0);
    drive(rnd(), rnd(), rnd(), rnd(), 1'b1);
    repeat (20) drive(rnd(), rnd(), rnd(), rnd(), 1'b0);
    for (int i = 0; i < 400; i++) drive(rnd(), rnd(), rnd(), rnd(), $urandom_range(0, 39) == 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/buffer_metrics_unit.md
Name: buffer_metrics_unit

Overview:
- Metrics front-end for the four-queue packet reader.
- Counts valid packets in each of four 18-bit packed buffers and derives reliability and latency scores from the counts.
- Also produces the slow scheduling clock and tick that pace one read decision per period (3 s at 50 MHz).
- Output is consumed by the reader FSM, which selects a mode and a buffer to shift.

Parameters:
- DIV_HALF, 75000000, clock cycles per half-period of clk_out. Must be ≥1. Counter width is $clog2(DIV_HALF) (minimum 1).

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous reset, active-high.
- buffer1_o  in  18  buffer 1: six 3-bit slots; slot k = bits [3k+2:3k]; bit 3k = valid, bits [3k+2:3k+1] = data.
- buffer2_o  in  18  buffer 2, same layout.
- buffer3_o  in  18  buffer 3, same layout.
- buffer4_o  in  18  buffer 4, same layout.
- L1  out  3  number of valid slots in buffer1_o (0..6).
- L2  out  3  number of valid slots in buffer2_o.
- L3  out  3  number of valid slots in buffer3_o.
- L4  out  3  number of valid slots in buffer4_o.
- RS  out  6  reliability score.
- LS  out  6  latency score.
- rel_mode  out  1  1 when RS ≥ LS (reliability mode), else 0 (latency mode).
- clk_out  out  1  divided square wave, 50% duty, period 2*DIV_HALF cycles.
- tick  out  1  one-cycle pulse coincident with each 0→1 transition of clk_out.

Behaviour:
- Reset (rst=1 at a clk edge) clears L1–L4, RS, LS, rel_mode, clk_out, tick and the divider counter to 0. Reset mid-period discards the partial count; the next period restarts from 0.
- Counting:
  - Li = popcount of bits {0,3,6,9,12,15} of bufferi_o.
  - Data bits are ignored; a slot with data but valid=0 is not counted.
  - Registered with 1-cycle latency: inputs sampled at edge n appear on L1–L4 after edge n.
- Scoring, computed combinationally from the current inputs (not from the registered L values) and registered on the same edge as L1–L4, so Li, RS, LS and rel_mode are mutually consistent every cycle:
  - RS = 1*L1 + 2*L2 + 3*L3 + 4*L4 (buffer 4 most reliable).
  - LS = 4*L1 + 3*L2 + 2*L3 + 1*L4 (buffer 1 lowest latency).
  - Unsigned arithmetic; maximum 60, so 6 bits never overflow.
- Mode: rel_mode = (RS ≥ LS). A tie, including all buffers empty, selects reliability (1).
- Divider:
  - Counter runs 0..DIV_HALF-1 and increments every cycle.
  - On the cycle it equals DIV_HALF-1 it wraps to 0 and clk_out toggles.
  - tick is registered: it is 1 in exactly the cycle in which clk_out becomes 1, else 0.
  - First clk_out rise occurs DIV_HALF edges after reset release; then every 2*DIV_HALF edges.
  - DIV_HALF=1: clk_out toggles every cycle, and tick is high every other cycle.
- Inputs may change every cycle. There is no handshake; outputs always reflect inputs from one cycle earlier.
- clk_out is a data signal in the clk domain. Downstream logic uses tick as an enable, never clk_out as a clock.

Test Plan:
- Reset: assert rst 2 cycles with arbitrary inputs -> L1–L4=0, RS=LS=0, rel_mode=0, clk_out=0, tick=0; after release, outputs track inputs with 1-cycle latency.
- Counting/scoring: buffer1_o=18'h09249, buffer2_o=0, buffer3_o=18'h00001, buffer4_o=18'h00009 -> next cycle L1=6, L2=0, L3=1, L4=2, RS=17, LS=28, rel_mode=0.
- Valid-bit masking: buffer2_o=18'h36DB6 (all data bits set, all valid=0), others 0 -> L2=0, RS=LS=0, rel_mode=1 (tie).
- Reliability mode: buffer4_o=18'h09249, others 0 -> L4=6, RS=24, LS=6, rel_mode=1. All four buffers full -> each Li=6, RS=LS=60, rel_mode=1.
- Divider with DIV_HALF=4: release reset -> clk_out rises after 4th edge, falls after 8th, rises after 12th; tick high only in the cycles clk_out rises; assert rst at edge 6 -> clk_out=0, next rise 4 edges after release.
- Back-to-back input change: change buffer3_o from 18'h00000 to 18'h09249 for a single cycle -> L3 shows 6 for exactly one cycle, with RS/LS updated in that same cycle.
